// File: rtl/cpu_int_pkg.sv
// Shared definitions for the interrupt controller.
//   - FSM state encodings (IDLE / REQ / SERV)
//   - id_width(): bits needed to index NSRC sources (clog2, minimum 1)
package cpu_int_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
    localparam logic [ST_W-1:0] ST_SERV = 2'd2;

    // Width of a source index; never below one bit so ports stay legal.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : cpu_int_pkg

// File: rtl/cpu_int_prio.sv
// Combinational fixed-priority encoder: lowest set index wins.
//   req   : pending & enabled sources
//   sel_c : index of the winning source (0 when none)
//   any_c : at least one source requesting
module cpu_int_prio #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [NSRC-1:0] req,
    output logic [ID_W-1:0] sel_c,
    output logic            any_c
);

    // Scan from the top so the lowest requesting index overwrites last.
    always_comb begin
        sel_c = '0;
        any_c = |req;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_c = ID_W'(i);
            end
        end
    end

endmodule : cpu_int_prio

// File: rtl/cpu_int_ctrl.sv
// Interrupt controller in front of the cpu interrupt input.
// Edge-detects NSRC raw lines into a pending register, masks them with a
// cpu-writable enable register, and presents the lowest-index enabled source
// to the cpu through a req/ack/done handshake (no nesting, no preemption).
//   clk, reset  : clock, synchronous active-low reset
//   irq_in      : raw interrupt lines (rising edge significant)
//   mask_we/wdata, mask_q : enable register write port and current value
//   pending     : pending register
//   int_req/int_ack/int_done : handshake with the cpu
//   int_id/int_vec : selected source and its handler address
module cpu_int_ctrl
    import cpu_int_pkg::*;
#(
    parameter int unsigned      NSRC       = 4,
    parameter int unsigned      VEC_W      = 10,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'('h3F0),
    parameter int unsigned      VEC_STRIDE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NSRC-1:0]               irq_in,
    input  logic                          mask_we,
    input  logic [NSRC-1:0]               mask_wdata,
    output logic [NSRC-1:0]               mask_q,
    output logic [NSRC-1:0]               pending,
    output logic                          int_req,
    input  logic                          int_ack,
    input  logic                          int_done,
    output logic [id_width(NSRC)-1:0]     int_id,
    output logic [VEC_W-1:0]              int_vec
);

    localparam int unsigned ID_W = id_width(NSRC);

    logic [NSRC-1:0]  irq_s_q,   irq_s_d;
    logic [NSRC-1:0]  irq_dly_q, irq_dly_d;
    logic [NSRC-1:0]  pending_q, pending_d;
    logic [NSRC-1:0]  mask_d;
    logic [ST_W-1:0]  state_q,   state_d;
    logic             int_req_q, int_req_d;
    logic [ID_W-1:0]  int_id_q,  int_id_d;
    logic [VEC_W-1:0] int_vec_q, int_vec_d;

    logic [NSRC-1:0]  rise_c;
    logic [NSRC-1:0]  id_onehot_c;
    logic [ID_W-1:0]  sel_c;
    logic             any_c;
    logic             ack_take_c;
    logic [VEC_W-1:0] vec_c;

    // Two-flop input stage; a rising edge is "new high, old low".
    always_comb begin
        irq_s_d   = irq_in;
        irq_dly_d = irq_s_q;
        rise_c    = irq_s_q & ~irq_dly_q;
    end

    // Enable register write port.
    always_comb begin
        mask_d = mask_q;
        if (mask_we) begin
            mask_d = mask_wdata;
        end
    end

    cpu_int_prio #(
        .NSRC (NSRC),
        .ID_W (ID_W)
    ) u_prio (
        .req   (pending_q & mask_q),
        .sel_c (sel_c),
        .any_c (any_c)
    );

    // Handler address, wrapping modulo 2^VEC_W.
    always_comb begin
        vec_c = VEC_BASE + (VEC_W'(sel_c) * VEC_W'(VEC_STRIDE));
    end

    // One-hot of the source currently held in int_id.
    always_comb begin
        id_onehot_c = NSRC'(1) << int_id_q;
    end

    // Handshake FSM.
    always_comb begin
        state_d    = state_q;
        int_req_d  = int_req_q;
        int_id_d   = int_id_q;
        int_vec_d  = int_vec_q;
        ack_take_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                int_req_d = 1'b0;
                if (any_c) begin
                    int_id_d  = sel_c;
                    int_vec_d = vec_c;
                    int_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // Ack has priority over a coincident done or a mask drop.
                if (int_ack) begin
                    ack_take_c = 1'b1;
                    int_req_d  = 1'b0;
                    state_d    = ST_SERV;
                end else if (~|(mask_q & id_onehot_c)) begin
                    int_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SERV: begin
                int_req_d = 1'b0;
                if (int_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                int_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Pending: a fresh edge on the same bit beats the acknowledge clear.
    always_comb begin
        pending_d = pending_q;
        if (ack_take_c) begin
            pending_d = pending_d & ~id_onehot_c;
        end
        pending_d = pending_d | rise_c;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_s_q   <= '0;
            irq_dly_q <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
            int_vec_q <= '0;
        end else begin
            irq_s_q   <= irq_s_d;
            irq_dly_q <= irq_dly_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            int_req_q <= int_req_d;
            int_id_q  <= int_id_d;
            int_vec_q <= int_vec_d;
        end
    end

    assign pending = pending_q;
    assign int_req = int_req_q;
    assign int_id  = int_id_q;
    assign int_vec = int_vec_q;

endmodule : cpu_int_ctrl

// File: tb/tb_cpu_int_ctrl.sv
// Directed bench for cpu_int_ctrl: a default instance plus one with a base
// address near the top of the vector space to exercise wrap-around.
module tb_cpu_int_ctrl;

    typedef struct packed {
        logic [1:0] id;
        logic [9:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] mask_q;
    logic [3:0] pending;
    logic       int_req;
    logic       int_ack;
    logic       int_done;
    logic [1:0] int_id;
    logic [9:0] int_vec;

    logic       w_reset;
    logic [3:0] w_irq;
    logic       w_mask_we;
    logic [3:0] w_mask_wdata;
    logic [3:0] w_mask_q;
    logic [3:0] w_pending;
    logic       w_req;
    logic       w_ack;
    logic       w_done;
    logic [1:0] w_id;
    logic [9:0] w_vec;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cpu_int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask_q     (mask_q),
        .pending    (pending),
        .int_req    (int_req),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .int_id     (int_id),
        .int_vec    (int_vec)
    );

    cpu_int_ctrl #(.VEC_BASE(10'h3F8)) dut_w (
        .clk        (clk),
        .reset      (w_reset),
        .irq_in     (w_irq),
        .mask_we    (w_mask_we),
        .mask_wdata (w_mask_wdata),
        .mask_q     (w_mask_q),
        .pending    (w_pending),
        .int_req    (w_req),
        .int_ack    (w_ack),
        .int_done   (w_done),
        .int_id     (w_id),
        .int_vec    (w_vec)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        irq_in   = '0;
        mask_we  = 1'b0;
        int_ack  = 1'b0;
        int_done = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    task automatic set_mask(input logic [3:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        step(1);
        mask_we = 1'b0;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        step(1);
        int_done = 1'b0;
    endtask

    // Scoreboard pop: compare the presented request against the oldest expectation.
    task automatic pop_check(input string tag);
        exp_t e;
        vectors++;
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_id"},  32'(int_id),  32'(e.id));
            chk({tag, "_vec"}, 32'(int_vec), 32'(e.vec));
        end
    endtask

    // Bounded wait for a request, then score it.
    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (int_req !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_req"}, 32'(int_req), 32'd1);
        pop_check(tag);
    endtask

    initial begin
        reset        = 1'b0;
        irq_in       = 4'b1111;
        mask_we      = 1'b0;
        mask_wdata   = '0;
        int_ack      = 1'b0;
        int_done     = 1'b0;
        w_reset      = 1'b0;
        w_irq        = '0;
        w_mask_we    = 1'b0;
        w_mask_wdata = '0;
        w_ack        = 1'b0;
        w_done       = 1'b0;

        // Reset and idle
        step(2);
        chk("rst_req",     32'(int_req), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mask",    32'(mask_q),  32'd0);
        chk("rst_id",      32'(int_id),  32'd0);
        chk("rst_vec",     32'(int_vec), 32'd0);
        reset = 1'b1;
        step(2);
        chk("idle_pending", 32'(pending), 32'hF);
        step(3);
        chk("idle_masked_req", 32'(int_req), 32'd0);

        // Single interrupt with latency check
        do_reset();
        set_mask(4'b0100);
        irq_in = 4'b0100;
        exp_q.push_back('{id: 2'd2, vec: 10'h3F8});
        step(2);
        chk("single_lat_k1", 32'(int_req), 32'd0);
        step(1);
        chk("single_lat_k2", 32'(int_req), 32'd1);
        pop_check("single");
        pulse_ack();
        chk("single_ack_req",     32'(int_req), 32'd0);
        chk("single_ack_pending", 32'(pending), 32'd0);
        step(2);
        chk("single_serv_req", 32'(int_req), 32'd0);
        pulse_done();
        irq_in = '0;
        step(3);
        chk("single_idle_req", 32'(int_req), 32'd0);

        // Priority, no preemption, done ignored in REQ
        do_reset();
        set_mask(4'b1111);
        irq_in = 4'b1000;
        exp_q.push_back('{id: 2'd3, vec: 10'h3FC});
        wait_req("prio3", 10);
        irq_in = 4'b1010;
        pulse_done();
        step(3);
        chk("prio_hold_req",     32'(int_req), 32'd1);
        chk("prio_hold_id",      32'(int_id),  32'd3);
        chk("prio_hold_vec",     32'(int_vec), 32'h3FC);
        chk("prio_hold_pending", 32'(pending), 32'hA);
        exp_q.push_back('{id: 2'd1, vec: 10'h3F4});
        pulse_ack();
        chk("prio_ack_pending", 32'(pending), 32'h2);
        chk("prio_ack_req",     32'(int_req), 32'd0);
        pulse_done();
        wait_req("prio1", 10);
        pulse_ack();
        pulse_done();
        irq_in = '0;

        // Withdraw on mask drop, then re-request, then reset mid-handshake
        do_reset();
        set_mask(4'b0001);
        irq_in = 4'b0001;
        exp_q.push_back('{id: 2'd0, vec: 10'h3F0});
        wait_req("wd0", 10);
        set_mask(4'b0000);
        chk("wd_still_req", 32'(int_req), 32'd1);
        step(1);
        chk("wd_drop_req", 32'(int_req), 32'd0);
        chk("wd_pending",  32'(pending), 32'd1);
        step(2);
        chk("wd_idle_req", 32'(int_req), 32'd0);
        exp_q.push_back('{id: 2'd0, vec: 10'h3F0});
        set_mask(4'b0001);
        wait_req("wd_re", 5);
        reset = 1'b0;
        step(1);
        chk("midrst_req",     32'(int_req), 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);

        // Set/clear collision with coincident ack+done
        do_reset();
        set_mask(4'b0100);
        irq_in = 4'b0100;
        exp_q.push_back('{id: 2'd2, vec: 10'h3F8});
        wait_req("col", 10);
        irq_in = '0;
        step(3);
        irq_in = 4'b0100;
        step(1);
        int_ack  = 1'b1;
        int_done = 1'b1;
        step(1);
        int_ack  = 1'b0;
        int_done = 1'b0;
        chk("col_pending", 32'(pending), 32'h4);
        chk("col_req",     32'(int_req), 32'd0);
        step(2);
        chk("col_serv_req", 32'(int_req), 32'd0);
        exp_q.push_back('{id: 2'd2, vec: 10'h3F8});
        pulse_done();
        wait_req("col_re", 5);
        pulse_ack();
        pulse_done();
        irq_in = '0;

        // Level-held irq yields one event
        do_reset();
        irq_in = 4'b0010;
        step(10);
        chk("lvl_pending", 32'(pending), 32'h2);
        chk("lvl_req",     32'(int_req), 32'd0);
        set_mask(4'b0010);
        exp_q.push_back('{id: 2'd1, vec: 10'h3F4});
        wait_req("lvl", 5);
        pulse_ack();
        chk("lvl_ack_pending", 32'(pending), 32'd0);
        step(5);
        chk("lvl_hold_pending", 32'(pending), 32'd0);
        pulse_done();
        step(3);
        chk("lvl_after_req",     32'(int_req), 32'd0);
        chk("lvl_after_pending", 32'(pending), 32'd0);
        irq_in = '0;

        // Vector wrap and reset in SERV on the high-base instance
        w_reset      = 1'b1;
        w_mask_we    = 1'b1;
        w_mask_wdata = 4'b1000;
        w_irq        = 4'b1000;
        step(1);
        w_mask_we = 1'b0;
        begin
            int n = 0;
            while (w_req !== 1'b1 && n < 10) begin
                step(1);
                n++;
            end
        end
        chk("wrap_req", 32'(w_req), 32'd1);
        chk("wrap_id",  32'(w_id),  32'd3);
        chk("wrap_vec", 32'(w_vec), 32'h004);
        w_ack = 1'b1;
        step(1);
        w_ack = 1'b0;
        chk("wrap_ack_req",     32'(w_req),     32'd0);
        chk("wrap_ack_pending", 32'(w_pending), 32'd0);
        w_irq = 4'b1001;
        step(3);
        chk("wrap_serv_pending", 32'(w_pending), 32'h1);
        w_reset = 1'b0;
        step(1);
        chk("wrap_rst_req",     32'(w_req),     32'd0);
        chk("wrap_rst_pending", 32'(w_pending), 32'd0);
        chk("wrap_rst_mask",    32'(w_mask_q),  32'd0);
        chk("wrap_rst_vec",     32'(w_vec),     32'd0);
        w_irq   = '0;
        w_reset = 1'b1;
        step(4);
        chk("wrap_idle_req", 32'(w_req), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cpu_int_ctrl

// File: doc/cpu_int_ctrl.md
Name: cpu_int_ctrl

Overview:
Interrupt controller placed in front of the cpu's interrupt input. It edge-detects NSRC external interrupt lines and latches them as pending. It applies a cpu-writable enable mask, then picks the highest-priority enabled source (lowest index). It presents one request at a time to the cpu with a vector address, using a request/acknowledge/done handshake. There is no nesting and no preemption.

Parameters:
NSRC, 4, number of interrupt sources (2..8)
VEC_W, 10, width of the vector address (matches the cpu instruction-memory address width)
VEC_BASE, 10'h3F0, vector address of source 0
VEC_STRIDE, 4, address distance between consecutive source vectors

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  reset is synchronous and active-low
irq_in  in  NSRC  raw interrupt lines, active-high, rising-edge significant
mask_we  in  1  write strobe for the enable register
mask_wdata  in  NSRC  new enable value (bit=1 enables the source)
mask_q  out  NSRC  current enable register
pending  out  NSRC  current pending register
int_req  out  1  interrupt request to the cpu (drives the cpu ir1 input)
int_ack  in  1  one-cycle pulse from the cpu: request accepted
int_done  in  1  one-cycle pulse from the cpu: return from interrupt
int_id  out  clog2(NSRC)  index of the source being requested or serviced
int_vec  out  VEC_W  handler address for int_id

Behaviour:
- Reset (reset==0 at a rising edge):
  - irq_s, irq_d, pending, mask_q, int_req, int_id and int_vec all go to 0.
  - state goes to IDLE.
  - A reset asserted mid-handshake aborts it: int_req is low after that edge.
- Input stage:
  - irq_s <= irq_in; irq_d <= irq_s; edge = irq_s & ~irq_d.
  - pending[i] <= 1 on edge[i], whether or not the source is enabled.
  - A level held high produces a single event.
- Pending clear: pending[int_id] <= 0 on the accepted int_ack. If a new edge arrives on the same bit in the same cycle, set wins.
- Enable register: when mask_we=1, mask_q <= mask_wdata, effective from the next cycle.
- Priority: sel = lowest index i with pending[i] & mask_q[i]. The encoder is combinational.
- Latency: irq_in high before edge k, with the source enabled and the controller IDLE, gives int_req=1 after edge k+2.
- State machine (registered outputs):
  - IDLE, int_req=0:
    - if |(pending & mask_q): latch int_id<=sel and int_vec<=VEC_BASE+sel*VEC_STRIDE, set int_req<=1, go to REQ.
  - REQ, int_req=1, int_id and int_vec held stable:
    - int_ack=1: pending[int_id]<=0, int_req<=0, go to SERV.
    - else if mask_q[int_id]==0: withdraw the request. int_req<=0, go to IDLE; pending is kept.
    - A higher-priority arrival does not change int_id.
  - SERV, int_req=0:
    - new requests are not issued; pending keeps accumulating.
    - int_done=1: go to IDLE. A new request can be issued on the following edge.
- Ignored inputs:
  - int_ack outside REQ is ignored.
  - int_done outside SERV is ignored.
  - If int_ack and int_done arrive together in REQ, only int_ack is acted upon.
- Vector arithmetic: computed at VEC_W bits with unsigned wrap (mod 2^VEC_W). There is no overflow flag.
- int_id and int_vec keep their last value in SERV and IDLE until the next selection.

Decomposition:
- Shared package cpu_int_pkg:
  - state encoding IDLE=2'd0, REQ=2'd1, SERV=2'd2
  - function computing the id width clog2(NSRC)
- Sub-module cpu_int_prio: combinational priority encoder.
  - inputs: pending & mask_q
  - outputs: sel, any
- Top level holds the synchronizer, the pending and enable registers, the FSM and the vector adder.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset=0 for 2 cycles with irq_in=4'b1111.
  - Response: all outputs 0. After release with mask_q=0, pending=4'b1111 but int_req stays 0.
- Single interrupt:
  - Stimulus: mask 4'b0100, raise irq_in[2] before edge k.
  - Response: int_req=1 after k+2, int_id=2, int_vec=10'h3F8. int_ack pulse gives int_req=0 and pending=0. int_done returns to IDLE.
- Priority and no preemption:
  - Stimulus: mask 4'b1111, raise irq[3]. While in REQ, raise irq[1].
  - Response: int_id stays 3 (int_vec 10'h3FC). After ack and done, the next request is int_id=1, int_vec=10'h3F4.
- Withdraw:
  - Stimulus: in REQ for id 0, write mask 4'b0000.
  - Response: int_req drops one edge later, state IDLE, pending[0] still 1. Re-enabling re-requests id 0.
- Set/clear collision and level irq:
  - Stimulus: a new edge on irq[2] in the same cycle as int_ack for id 2. Separately, hold irq[1] high for 10 cycles.
  - Response: pending[2] stays 1. irq[1] produces exactly one pending event.
- Vector wrap and mid-operation reset:
  - Stimulus: instance with VEC_BASE=10'h3F8; request id 3. Then assert reset in SERV.
  - Response: int_vec=10'h004. Reset returns to IDLE with int_req=0 and pending=0.
